// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 instruction fetch path.
package chip8_pkg;

  localparam logic [11:0] PROG_START = 12'h200;
  localparam int          INSTR_W    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_HI  = 3'd1,
    RD_LO  = 3'd2,
    CAP_LO = 3'd3,
    VALID  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/chip8_pc_next.sv
// Next program counter selection applied when the CPU accepts an opcode.
// Branch beats skip; all arithmetic wraps at the address width.
module chip8_pc_next #(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              skip_en,
  output logic [ADDR_W-1:0] next_pc
);

  // Priority mux: jump target, then skip over the next opcode, then sequential.
  always_comb begin
    next_pc = instr_pc + ADDR_W'(2);
    if (branch_en) begin
      next_pc = branch_addr;
    end else if (skip_en) begin
      next_pc = instr_pc + ADDR_W'(4);
    end
  end

endmodule

// File: rtl/chip8_fetch_unit.sv
// Fetch stage: reads a big-endian opcode as two bytes from program RAM and
// presents it to the CPU over a valid/ready handshake. Owns the PC.
module chip8_fetch_unit
  import chip8_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PROG_START)
) (
  input  logic              cpu_clk,
  input  logic              reset_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              skip_en
);

  fetch_state_t         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [7:0]           hi_q, hi_d;
  logic [INSTR_W-1:0]   instruction_q, instruction_d;
  logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]    next_pc;
  logic                 accept;

  chip8_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .instr_pc    (instr_pc_q),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .skip_en     (skip_en),
    .next_pc     (next_pc)
  );

  // Outputs are decoded from registered state so reset values appear immediately.
  always_comb begin
    mem_rd      = (state_q == RD_HI) || (state_q == RD_LO);
    mem_addr    = (state_q == RD_LO) ? pc_q + ADDR_W'(1) : pc_q;
    instr_valid = (state_q == VALID);
    instruction = instruction_q;
    instr_pc    = instr_pc_q;
    accept      = instr_valid && instr_ready;
  end

  // FSM sequencing and data capture; redirect inputs only matter on accept.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hi_d          = hi_q;
    instruction_d = instruction_q;
    instr_pc_d    = instr_pc_q;
    case (state_q)
      IDLE:   if (run) state_d = RD_HI;
      RD_HI:  state_d = RD_LO;
      RD_LO: begin
        hi_d    = mem_rdata;
        state_d = CAP_LO;
      end
      CAP_LO: begin
        instruction_d = {hi_q, mem_rdata};
        instr_pc_d    = pc_q;
        state_d       = VALID;
      end
      VALID: begin
        if (accept) begin
          pc_d    = next_pc;
          state_d = run ? RD_HI : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any partially fetched opcode.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      hi_q          <= 8'h00;
      instruction_q <= '0;
      instr_pc_q    <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hi_q          <= hi_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

endmodule
